// File: rtl/dmem_resp.sv
// Data-memory responder: serves one load/store at a time after WAIT_CYCLES wait states.
// Optional address-range checking is enabled with `define DMEM_RANGE_CHK_EN.
module dmem_resp #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [15:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        busy_o,
  output logic        err_o
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic          oor;
  logic          do_acc;
  logic          mem_we;

  assign idx = addr_q[AW-1:0];

`ifdef DMEM_RANGE_CHK_EN
  assign oor = |(addr_q >> AW);
`else
  assign oor = 1'b0;
`endif

  assign do_acc = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign mem_we = do_acc && we_q && !oor;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_CYCLES);
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end
      end
      ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = RESP;
          err_d   = oor;
          if (!we_q) rdata_d = oor ? 32'd0 : mem[idx];
        end
      end
      RESP: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 16'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // No reset on the array; a reset mid-access parks state_q in IDLE, so mem_we stays low.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= wdata_q;
  end

  assign ack_o   = (state_q == RESP);
  assign rdata_o = rdata_q;
  assign err_o   = err_q;
  assign busy_o  = (state_q == ACCESS) || ((state_q == IDLE) && req_i);

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: three instances with WAIT_CYCLES = 1, 0, 3 on one clock.
module tb_dmem_resp;
  logic        clk;
  logic        rst   [3];
  logic        req   [3];
  logic        we    [3];
  logic [15:0] addr  [3];
  logic [31:0] wdata [3];
  logic        ack   [3];
  logic [31:0] rdata [3];
  logic        busy  [3];
  logic        err   [3];

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] last_rd;
  logic        last_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WC = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    dmem_resp #(.DEPTH(1024), .WAIT_CYCLES(WC)) u_dut (
      .clk     (clk),
      .rst     (rst[g]),
      .req_i   (req[g]),
      .we_i    (we[g]),
      .addr_i  (addr[g]),
      .wdata_i (wdata[g]),
      .ack_o   (ack[g]),
      .rdata_o (rdata[g]),
      .busy_o  (busy[g]),
      .err_o   (err[g])
    );
  end

  function automatic int wc_of(input int k);
    return (k == 0) ? 1 : (k == 1) ? 0 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One full access; checks latency and busy_o along the way, leaves result in last_rd/last_err.
  task automatic acc(input int k, input logic w, input logic [15:0] a,
                     input logic [31:0] d, input string tag);
    int   lat;
    logic busy_ok;
    logic got;
    lat = 0; busy_ok = 1'b1; got = 1'b0;
    @(posedge clk); #1;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ack[k]) begin
        got      = 1'b1;
        last_rd  = rdata[k];
        last_err = err[k];
        chk({tag, "_busy_ack"}, 32'(busy[k]), 32'd0);
        req[k] = 1'b0;
        break;
      end
      if (!busy[k]) busy_ok = 1'b0;
      lat++;
    end
    chk({tag, "_ack"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(wc_of(k) + 2));
    chk({tag, "_busy"}, 32'(busy_ok), 32'd1);
  endtask

  initial begin
    logic [8:0] ackmask;
    int         nack;
    logic [31:0] exp_rd;

    for (int k = 0; k < 3; k++) begin
      rst[k] = 1'b0; req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_ack%0d", k), 32'(ack[k]), 32'd0);
      chk($sformatf("rst_rd%0d", k), rdata[k], 32'd0);
      chk($sformatf("rst_err%0d", k), 32'(err[k]), 32'd0);
      chk($sformatf("rst_busy%0d", k), 32'(busy[k]), 32'd0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) rst[k] = 1'b1;

    // WAIT_CYCLES=1 store/load, rdata held across a later store
    acc(0, 1'b1, 16'h0010, 32'hDEADBEEF, "st10");
    acc(0, 1'b0, 16'h0010, 32'h0, "ld10");
    chk("ld10_rd", last_rd, 32'hDEADBEEF);
    chk("ld10_err", 32'(last_err), 32'd0);
    acc(0, 1'b1, 16'h0011, 32'h00005555, "st11");
    chk("rd_hold", rdata[0], 32'hDEADBEEF);
    acc(0, 1'b0, 16'h0011, 32'h0, "ld11");
    chk("ld11_rd", last_rd, 32'h00005555);

    // WAIT_CYCLES=0, req_i held high with alternating load addresses
    acc(1, 1'b1, 16'h0001, 32'h000000A1, "w0st1");
    acc(1, 1'b1, 16'h0002, 32'h000000B2, "w0st2");
    @(posedge clk); #1;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0001;
    ackmask = '0; nack = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (ack[1]) begin
        ackmask[i] = 1'b1;
        exp_rd = (nack % 2 == 0) ? 32'h000000A1 : 32'h000000B2;
        chk($sformatf("hold_rd%0d", nack), rdata[1], exp_rd);
        nack++;
        addr[1] = (addr[1] == 16'h0001) ? 16'h0002 : 16'h0001;
      end
    end
    req[1] = 1'b0;
    chk("hold_ackmask", 32'(ackmask), 32'h124);

    // WAIT_CYCLES=3, reset during ACCESS abandons the store
    acc(2, 1'b1, 16'h0020, 32'h11112222, "w3old");
    @(posedge clk); #1;
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 16'h0020; wdata[2] = 32'h12345678;
    @(posedge clk); #1;
    rst[2] = 1'b0; req[2] = 1'b0;
    #2 rst[2] = 1'b1;
    nack = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack[2]) nack++;
    end
    chk("rst_mid_noack", 32'(nack), 32'd0);
    chk("rst_mid_busy", 32'(busy[2]), 32'd0);
    acc(2, 1'b0, 16'h0020, 32'h0, "w3ld");
    chk("rst_mid_old", last_rd, 32'h11112222);

    // Out-of-range / aliasing at DEPTH=1024
    acc(0, 1'b1, 16'h0000, 32'h01020304, "st0");
    acc(0, 1'b1, 16'h0400, 32'hAAAA5555, "st400");
`ifdef DMEM_RANGE_CHK_EN
    chk("st400_err", 32'(last_err), 32'd1);
    acc(0, 1'b0, 16'h0000, 32'h0, "ld0");
    chk("ld0_rd", last_rd, 32'h01020304);
    chk("ld0_err", 32'(last_err), 32'd0);
    acc(0, 1'b0, 16'h0400, 32'h0, "ld400");
    chk("ld400_rd", last_rd, 32'h0);
    chk("ld400_err", 32'(last_err), 32'd1);
`else
    chk("st400_err", 32'(last_err), 32'd0);
    acc(0, 1'b0, 16'h0000, 32'h0, "ld0");
    chk("ld0_rd", last_rd, 32'hAAAA5555);
    chk("ld0_err", 32'(last_err), 32'd0);
    acc(0, 1'b0, 16'h0400, 32'h0, "ld400");
    chk("ld400_rd", last_rd, 32'hAAAA5555);
    chk("ld400_err", 32'(last_err), 32'd0);
`endif
    @(negedge clk);
    chk("err_idle", 32'(err[0]), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
